// File: rtl/beatloop_pkg.sv
// Shared definitions for the beat-loop sequencer: mode encodings and note constants.
package beatloop_pkg;

  localparam int NOTE_W = 8;
  localparam logic [NOTE_W-1:0] NOTE_REST = '0;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_RECORD = 2'd1,
    MODE_PLAY   = 2'd2,
    MODE_CLEAR  = 2'd3
  } mode_e;

endpackage

// File: rtl/step_timer.sv
// Tempo grid: tick counter within a step, step counter across the loop, boundary strobe.
module step_timer #(
  parameter int STEPS          = 16,
  parameter int TICKS_PER_STEP = 6_250_000,
  localparam int STEP_W        = $clog2(STEPS),
  localparam int TICK_W        = $clog2(TICKS_PER_STEP)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic              restart,
  output logic [STEP_W-1:0] step,
  output logic              step_pulse
);

  logic [TICK_W-1:0] r_tick;
  logic [STEP_W-1:0] r_step;
  logic              w_term;

  assign w_term     = (r_tick == TICK_W'(TICKS_PER_STEP - 1));
  assign step_pulse = run & ~restart & w_term;
  assign step       = r_step;

  // STEPS is a power of two, so the step counter wraps on its own.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tick <= '0;
      r_step <= '0;
    end else if (restart) begin
      r_tick <= '0;
      r_step <= '0;
    end else if (run) begin
      if (w_term) begin
        r_tick <= '0;
        r_step <= r_step + 1'b1;
      end else begin
        r_tick <= r_tick + 1'b1;
      end
    end
  end

endmodule

// File: rtl/loop_sequencer.sv
// Beat-loop controller: records live notes on a tempo grid into a pattern memory and replays it.
module loop_sequencer
  import beatloop_pkg::*;
#(
  parameter int STEPS          = 16,
  parameter int TICKS_PER_STEP = 6_250_000,
  parameter int NOTE_W         = beatloop_pkg::NOTE_W,
  localparam int STEP_W        = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NOTE_W-1:0] live_note,
  input  logic              rec_btn,
  input  logic              play_btn,
  input  logic              clear_btn,
  output logic [NOTE_W-1:0] note_out,
  output logic [STEP_W-1:0] step,
  output logic              step_pulse,
  output logic [1:0]        mode
);

  localparam logic [NOTE_W-1:0] REST = NOTE_W'(NOTE_REST);

  mode_e             r_state;
  mode_e             w_next;
  logic              r_rec_d;
  logic              r_play_d;
  logic              r_clr_d;
  logic              w_rec_e;
  logic              w_play_e;
  logic              w_clr_e;
  logic              w_run;
  logic              w_restart;
  logic              w_pulse;
  logic [STEP_W-1:0] w_step;
  logic [STEP_W-1:0] r_clr_addr;
  logic [NOTE_W-1:0] r_cap;
  logic [NOTE_W-1:0] w_wv;
  logic [NOTE_W-1:0] r_mem [STEPS];
  logic [NOTE_W-1:0] w_note;
  logic [NOTE_W-1:0] r_note;

  // Previous-level flops reset high so a button held through reset needs a fresh press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rec_d  <= 1'b1;
      r_play_d <= 1'b1;
      r_clr_d  <= 1'b1;
    end else begin
      r_rec_d  <= rec_btn;
      r_play_d <= play_btn;
      r_clr_d  <= clear_btn;
    end
  end

  assign w_rec_e  = rec_btn   & ~r_rec_d  & (r_state != MODE_CLEAR);
  assign w_play_e = play_btn  & ~r_play_d & (r_state != MODE_CLEAR);
  assign w_clr_e  = clear_btn & ~r_clr_d  & (r_state != MODE_CLEAR);

  step_timer #(
    .STEPS          (STEPS),
    .TICKS_PER_STEP (TICKS_PER_STEP)
  ) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .run        (w_run),
    .restart    (w_restart),
    .step       (w_step),
    .step_pulse (w_pulse)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= MODE_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_restart = 1'b0;
    w_run     = (r_state == MODE_RECORD) || (r_state == MODE_PLAY);
    case (r_state)
      MODE_IDLE: begin
        if (w_clr_e) begin
          w_next = MODE_CLEAR;
        end else if (w_rec_e) begin
          w_next    = MODE_RECORD;
          w_restart = 1'b1;
        end else if (w_play_e) begin
          w_next    = MODE_PLAY;
          w_restart = 1'b1;
        end
      end
      MODE_RECORD: begin
        if (w_clr_e)                  w_next = MODE_CLEAR;
        else if (w_rec_e || w_play_e) w_next = MODE_PLAY;
      end
      MODE_PLAY: begin
        if (w_clr_e)       w_next = MODE_CLEAR;
        else if (w_rec_e)  w_next = MODE_RECORD;
        else if (w_play_e) w_next = MODE_IDLE;
      end
      MODE_CLEAR: begin
        w_restart = 1'b1;
        if (r_clr_addr == STEP_W'(STEPS - 1)) w_next = MODE_IDLE;
      end
      default: w_next = MODE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                   r_clr_addr <= '0;
    else if (r_state == MODE_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
    else                           r_clr_addr <= '0;
  end

  // Capture holds the first non-rest note of the step; it never survives a step or mode change.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                 r_cap <= '0;
    else if (r_state != MODE_RECORD || w_pulse)  r_cap <= '0;
    else if (r_cap == REST)                      r_cap <= live_note;
  end

  assign w_wv = (r_cap != REST) ? r_cap : live_note;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < STEPS; i++) r_mem[i] <= '0;
    end else if (r_state == MODE_CLEAR) begin
      r_mem[r_clr_addr] <= '0;
    end else if (r_state == MODE_RECORD && w_pulse && w_wv != REST) begin
      r_mem[w_step] <= w_wv;
    end
  end

  always_comb begin
    w_note = REST;
    case (r_state)
      MODE_IDLE:              w_note = live_note;
      MODE_RECORD, MODE_PLAY: w_note = (live_note != REST) ? live_note : r_mem[w_step];
      default:                w_note = REST;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_note <= '0;
    else         r_note <= w_note;
  end

  assign note_out   = r_note;
  assign step       = w_step;
  assign step_pulse = w_pulse;
  assign mode       = r_state;

endmodule
